div3_pulse_monitor: RTL
=======================

// Module: div3_pulse_monitor
// PURPOSE
//  Receiving end of the divide-by-3 pulse stream. Samples the divided output y (same clk domain), measures
//  the rising-edge-to-rising-edge period and declares lock after LOCK_COUNT consecutive correct periods.
//  Flags period errors and loss of pulses. Sits beside the divider as an in-system checker and bench monitor.
// PARAMETERS
//  DIV         3   expected period of y_in in clk cycles (>=2)
//  WIDTH       8   width of period counter/measurement; must hold TIMEOUT
//  LOCK_COUNT  4   consecutive good periods needed to assert locked (1..15)
//  TIMEOUT     12  clk cycles without a rising edge before declaring loss (default 4*DIV)
// PORTS
//  clk         in   1      single clock, all logic on posedge
//  reset       in   1      synchronous, active-high
//  y_in        in   1      divided pulse stream, synchronous to clk
//  locked      out  1      level: LOCK_COUNT good periods seen, no error since
//  period_vld  out  1      1-cycle pulse: period holds a new measurement
//  period      out  WIDTH  clocks between the last two rising edges
//  period_err  out  1      1-cycle pulse: bad period or timeout while MEASURE/LOCKED
//  err_count   out  8      saturating error count (only with DIV_MON_STATS_EN)
// BEHAVIOUR
//  - Reset (sync, active-high, overrides everything): state=IDLE, y_q=0, cnt=0, good=0, locked=0,
//    period_vld=0, period=0, period_err=0, err_count=0. Asserting reset mid-lock drops locked next edge.
//  - Rise detect: rise = y_in & ~y_q; y_q <= y_in every cycle. All outputs registered: a rise sampled at
//    edge k updates outputs visible after edge k.
//  - cnt: on rise -> 1; else if state!=IDLE -> cnt+1, saturating at 2^WIDTH-1.
//  - States: IDLE, MEASURE, LOCKED.
//    IDLE:    rise -> MEASURE, cnt=1, good=0. No period_vld on first edge.
//    MEASURE: rise -> period=cnt, period_vld=1; cnt==DIV ? good+1 : (good=0, period_err=1).
//             good+1==LOCK_COUNT -> LOCKED, locked=1 same edge.
//    LOCKED:  rise -> period=cnt, period_vld=1; cnt!=DIV -> period_err=1, locked=0, good=0, MEASURE.
//    Timeout: no rise and cnt==TIMEOUT in MEASURE/LOCKED -> period_err=1, locked=0, good=0, IDLE.
//  - Simultaneous rise and cnt==TIMEOUT: rise wins (measured as a bad period, no timeout).
//  - y_in stuck high: no further rises, so timeout applies. Period is rise-to-rise only; duty cycle unchecked.
//  - period_vld and period_err may assert in the same cycle. Both are single-cycle pulses.
// CONFIGURATION
//  DIV_MON_STATS_EN defined: err_count increments on every period_err pulse, saturates at 255,
//    cleared only by reset.
//  DIV_MON_STATS_EN undefined: err_count tied to 8'd0, no counter flops.
// STRUCTURE
//  div_mon_defs.vh (shared include): state encodings `DM_IDLE=2'd0, `DM_MEASURE=2'd1, `DM_LOCKED=2'd2,
//    plus default DIV/TIMEOUT constants reused by divider and monitor benches.
//  Sub-module rise_edge_det (clk, reset, d, q_d, rise): y_q register and rise output. Everything else
//    (counter, FSM, outputs) lives in div3_pulse_monitor.
// TESTING
//  1 Divider drives y_in, reset=1 for 10 time units then 0 -> period_vld every 3 clks with period=3;
//    locked=1 at the 4th good measurement; period_err never asserts.
//  2 Locked, then one period of 2 injected -> period=2, period_err=1, locked=0;
//    4 further good periods -> locked=1.
//  3 Locked, then y_in held low 12 clks -> period_err pulse at cnt==12, locked=0, state IDLE;
//    next rise gives no period_vld.
//  4 Reset asserted for 1 clk mid-lock -> all outputs 0 after that edge;
//    relock needs 1 first edge + 4 good periods.
//  5 y_in stuck high after lock -> timeout error exactly TIMEOUT clks after the last rise.
//  6 DIV_MON_STATS_EN: 300 injected errors -> err_count=255. Without the macro -> err_count=0 throughout.

Source files
------------

// File: rtl/div3_pulse_monitor_pkg.sv
// Shared state encoding and default timing constants for the divide-by-3 monitor
// and for the divider benches that drive it.
package div3_pulse_monitor_pkg;

  typedef enum logic [1:0] {
    DM_IDLE    = 2'd0,
    DM_MEASURE = 2'd1,
    DM_LOCKED  = 2'd2
  } dm_state_e;

  localparam int DM_DEF_DIV     = 3;
  localparam int DM_DEF_TIMEOUT = 4 * DM_DEF_DIV;

endpackage

// File: rtl/div3_pulse_monitor_rise_edge_det.sv
// One-flop rising-edge detector: q_d is the input delayed by one clk,
// rise is high while d is high and was low on the previous edge.
module rise_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q_d,
  output logic rise
);

  logic q_reg;

  always_ff @(posedge clk) begin
    if (reset) q_reg <= 1'b0;
    else       q_reg <= d;
  end

  assign q_d  = q_reg;
  assign rise = d & ~q_reg;

endmodule

// File: rtl/div3_pulse_monitor.sv
// Period checker for a divided pulse stream: measures rise-to-rise spacing, locks after
// LOCK_COUNT good periods, flags bad periods and lost pulses. Error counter: DIV_MON_STATS_EN.
module div3_pulse_monitor
  import div3_pulse_monitor_pkg::*;
#(
  parameter int DIV        = DM_DEF_DIV,
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = DM_DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             y_in,
  output logic             locked,
  output logic             period_vld,
  output logic [WIDTH-1:0] period,
  output logic             period_err,
  output logic [7:0]       err_count
);

  localparam logic [WIDTH-1:0] div_w     = WIDTH'(DIV);
  localparam logic [WIDTH-1:0] timeout_w = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] cnt_max   = '1;
  localparam logic [3:0]       lock_w    = 4'(LOCK_COUNT);

  logic             y_q;
  logic             rise;

  dm_state_e        state_reg,  state_next;
  logic [WIDTH-1:0] cnt_reg,    cnt_next;
  logic [3:0]       good_reg,   good_next;
  logic             locked_reg, locked_next;
  logic             vld_reg,    vld_next;
  logic [WIDTH-1:0] period_reg, period_next;
  logic             err_reg,    err_next;

  rise_edge_det u_rise (
    .clk   (clk),
    .reset (reset),
    .d     (y_in),
    .q_d   (y_q),
    .rise  (rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= DM_IDLE;
      cnt_reg    <= '0;
      good_reg   <= '0;
      locked_reg <= 1'b0;
      vld_reg    <= 1'b0;
      period_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      good_reg   <= good_next;
      locked_reg <= locked_next;
      vld_reg    <= vld_next;
      period_reg <= period_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    good_next   = good_reg;
    locked_next = locked_reg;
    vld_next    = 1'b0;
    period_next = period_reg;
    err_next    = 1'b0;
    if (rise)
      cnt_next = {{(WIDTH-1){1'b0}}, 1'b1};
    else if (state_reg != DM_IDLE && cnt_reg != cnt_max)
      cnt_next = cnt_reg + 1'b1;
    else
      cnt_next = cnt_reg;

    case (state_reg)
      DM_IDLE: begin
        if (rise) begin
          state_next = DM_MEASURE;
          good_next  = '0;
        end
      end
      DM_MEASURE: begin
        if (rise) begin
          vld_next    = 1'b1;
          period_next = cnt_reg;
          if (cnt_reg == div_w) begin
            good_next = good_reg + 4'd1;
            if (good_reg + 4'd1 == lock_w) begin
              state_next  = DM_LOCKED;
              locked_next = 1'b1;
            end
          end else begin
            good_next = '0;
            err_next  = 1'b1;
          end
        end else if (cnt_reg == timeout_w) begin
          err_next    = 1'b1;
          locked_next = 1'b0;
          good_next   = '0;
          state_next  = DM_IDLE;
        end
      end
      DM_LOCKED: begin
        // A rise landing on the timeout count is judged as a period, never as loss.
        if (rise) begin
          vld_next    = 1'b1;
          period_next = cnt_reg;
          if (cnt_reg != div_w) begin
            err_next    = 1'b1;
            locked_next = 1'b0;
            good_next   = '0;
            state_next  = DM_MEASURE;
          end
        end else if (cnt_reg == timeout_w) begin
          err_next    = 1'b1;
          locked_next = 1'b0;
          good_next   = '0;
          state_next  = DM_IDLE;
        end
      end
      default: begin
        state_next  = DM_IDLE;
        locked_next = 1'b0;
        good_next   = '0;
      end
    endcase
  end

  assign locked     = locked_reg;
  assign period_vld = vld_reg;
  assign period     = period_reg;
  assign period_err = err_reg;

`ifdef DIV_MON_STATS_EN
  logic [7:0] err_count_reg;

  // Counts alongside the error pulse so err_count moves on the same edge as period_err.
  always_ff @(posedge clk) begin
    if (reset)
      err_count_reg <= '0;
    else if (err_next && err_count_reg != 8'hFF)
      err_count_reg <= err_count_reg + 8'd1;
  end

  assign err_count = err_count_reg;
`else
  assign err_count = 8'd0;
`endif

endmodule
